audio_filter_sched: RTL and testbench

//  Time-multiplexes one shared audio filter engine (biquad MAC) across NUM_CH audio channels:
//  FM L/R, PSG and final mix L/R.
//  On each sample_ce it snapshots all channel inputs and issues one req/ack transfer per enabled channel.
//  It collects the filtered results and publishes all outputs atomically with a one-cycle out_valid.

---
 rtl/audio_sched_pkg.sv | 20 ++
 rtl/audio_sched_wdog.sv | 30 +++
 rtl/audio_filter_sched.sv | 168 ++++++++++++++++
 tb/tb_audio_filter_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the audio filter scheduler: FSM states,
// channel index map and the default channel count.
package audio_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ADV   = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

   localparam int CH_FM_L  = 0;
   localparam int CH_FM_R  = 1;
   localparam int CH_PSG   = 2;
   localparam int CH_MIX_L = 3;
   localparam int CH_MIX_R = 4;

   localparam int DEFAULT_NUM_CH = 5;

endpackage

// File: rtl/audio_sched_wdog.sv
// Wait-cycle watchdog for one engine request: counts enabled cycles and flags
// expiry on the TIMEOUT-th consecutive cycle without the request being served.
module audio_sched_wdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   // Expiry is combinational so the abort happens in the same cycle the limit is hit.
   assign o_expired = !i_clr && i_en && (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr || o_expired) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/audio_filter_sched.sv
// Time-multiplexes one shared biquad engine across NUM_CH audio channels:
// snapshot on sample_ce, one req/ack transfer per enabled channel, atomic publish.
module audio_filter_sched
   import audio_sched_pkg::*;
#(
   parameter int NUM_CH  = DEFAULT_NUM_CH,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_ce,
   input  logic [NUM_CH-1:0]        ch_enable,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     eng_req,
   output logic [2:0]               eng_ch,
   output logic [DATA_W-1:0]        eng_in,
   input  logic                     eng_ack,
   input  logic [DATA_W-1:0]        eng_out,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     overrun,
   output logic                     timeout_err,
   input  logic                     clr_err
);

   sched_state_t      r_state;
   logic [2:0]        r_idx;
   logic [NUM_CH-1:0] r_en_buf;
   logic [DATA_W-1:0] r_in_buf   [NUM_CH];
   logic [DATA_W-1:0] r_out_buf  [NUM_CH];
   logic [DATA_W-1:0] r_out_data [NUM_CH];
   logic              r_eng_req;
   logic [2:0]        r_eng_ch;
   logic [DATA_W-1:0] r_eng_in;
   logic              r_out_valid;
   logic              r_overrun;
   logic              r_timeout_err;

   logic [DATA_W-1:0] w_in_ch [NUM_CH];
   logic [2:0]        w_idx_nxt;
   logic              w_last;
   logic              w_wd_expired;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_pack
         assign w_in_ch[gi]                    = in_data[DATA_W*gi +: DATA_W];
         assign out_data[DATA_W*gi +: DATA_W]  = r_out_data[gi];
      end
   endgenerate

   assign w_idx_nxt   = r_idx + 3'd1;
   assign w_last      = (r_idx == 3'(NUM_CH - 1));

   assign eng_req     = r_eng_req;
   assign eng_ch      = r_eng_ch;
   assign eng_in      = r_eng_in;
   assign out_valid   = r_out_valid;
   assign busy        = (r_state != IDLE);
   assign overrun     = r_overrun;
   assign timeout_err = r_timeout_err;

   // Held in clear outside ISSUE, so every new request starts from zero.
   audio_sched_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (r_state != ISSUE),
      .i_en      (!eng_ack),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_en_buf      <= '0;
         r_eng_req     <= 1'b0;
         r_eng_ch      <= '0;
         r_eng_in      <= '0;
         r_out_valid   <= 1'b0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_in_buf[i]   <= '0;
            r_out_buf[i]  <= '0;
            r_out_data[i] <= '0;
         end
      end else begin
         r_out_valid <= 1'b0;

         // Error sets are written after the clear so a coincident event wins.
         if (clr_err) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
         end
         if (sample_ce && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (sample_ce) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     r_in_buf[i] <= w_in_ch[i];
                  end
                  r_en_buf <= ch_enable;
                  r_idx    <= '0;
                  if (ch_enable[0]) begin
                     r_state   <= ISSUE;
                     r_eng_req <= 1'b1;
                     r_eng_ch  <= '0;
                     r_eng_in  <= w_in_ch[0];
                  end else begin
                     r_state <= ADV;
                  end
               end
            end

            ISSUE: begin
               if (eng_ack) begin
                  r_out_buf[r_idx] <= eng_out;
                  r_eng_req        <= 1'b0;
                  r_state          <= ADV;
               end else if (w_wd_expired) begin
                  r_out_buf[r_idx] <= r_in_buf[r_idx];
                  r_timeout_err    <= 1'b1;
                  r_eng_req        <= 1'b0;
                  r_state          <= ADV;
               end
            end

            ADV: begin
               if (!r_en_buf[r_idx]) begin
                  r_out_buf[r_idx] <= r_in_buf[r_idx];
               end
               if (w_last) begin
                  r_state <= DONE;
               end else begin
                  r_idx <= w_idx_nxt;
                  if (r_en_buf[w_idx_nxt]) begin
                     r_state   <= ISSUE;
                     r_eng_req <= 1'b1;
                     r_eng_ch  <= w_idx_nxt;
                     r_eng_in  <= r_in_buf[w_idx_nxt];
                  end else begin
                     r_state <= ADV;
                  end
               end
            end

            DONE: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  r_out_data[i] <= r_out_buf[i];
               end
               r_out_valid <= 1'b1;
               r_state     <= IDLE;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_filter_sched.sv
// Directed bench for audio_filter_sched: latency, bypass, watchdog, overrun,
// snapshot isolation and asynchronous reset, against hand-computed vectors.
module tb_audio_filter_sched;

   localparam int NUM_CH  = 5;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 16;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     sample_ce = 1'b0;
   logic [NUM_CH-1:0]        ch_enable = '0;
   logic [NUM_CH*DATA_W-1:0] in_data = '0;
   logic                     eng_req;
   logic [2:0]               eng_ch;
   logic [DATA_W-1:0]        eng_in;
   logic                     eng_ack;
   logic [DATA_W-1:0]        eng_out;
   logic [NUM_CH*DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     busy;
   logic                     overrun;
   logic                     timeout_err;
   logic                     clr_err = 1'b0;

   int       n_chk  = 0;
   int       n_pass = 0;
   int       ack_mode = 0;      // 0: always ack, 1: never ack channel 2, 2: never ack
   int       xfer_total = 0;
   logic [14:0] ch_seq = '0;
   int       lat;
   int       x0;

   always #5 clk = ~clk;

   assign eng_ack = (ack_mode == 0) ? 1'b1 :
                    (ack_mode == 1) ? (eng_ch != 3'd2) : 1'b0;
   assign eng_out = eng_in ^ 16'hFFFF;

   audio_filter_sched #(
      .NUM_CH  (NUM_CH),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_ce   (sample_ce),
      .ch_enable   (ch_enable),
      .in_data     (in_data),
      .eng_req     (eng_req),
      .eng_ch      (eng_ch),
      .eng_in      (eng_in),
      .eng_ack     (eng_ack),
      .eng_out     (eng_out),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   // Transfer monitor: mid-cycle, while req/ack/ch are stable.
   always @(negedge clk) begin
      if (!reset && eng_req && eng_ack) begin
         xfer_total = xfer_total + 1;
         ch_seq     = {ch_seq[11:0], eng_ch};
      end
   end

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one pass; lat = edges from the sample_ce edge to out_valid (-1 if never).
   task automatic run_pass(input logic [4:0] en, input logic [79:0] din,
                           input int ce_a, input int ce_b, input int clr_at,
                           input bit scramble, output int lat_o);
      int n;
      @(negedge clk);
      ch_enable = en;
      in_data   = din;
      sample_ce = 1'b1;
      @(posedge clk);
      #1;
      sample_ce = 1'b0;
      n     = 0;
      lat_o = -1;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         sample_ce = (n == ce_a) || (n == ce_b);
         clr_err   = (n == clr_at);
         if (scramble) begin
            in_data   = {$urandom(), $urandom(), 16'($urandom())};
            ch_enable = 5'($urandom());
         end
         if (out_valid) begin
            lat_o = n;
            break;
         end
      end
      sample_ce = 1'b0;
      clr_err   = 1'b0;
      $display("pass en=%b in=%h lat=%0d out=%h ovr=%b tmo=%b", en, din, lat_o, out_data, overrun, timeout_err);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_busy",      80'(busy),      80'(0));
      chk("rst_eng_req",   80'(eng_req),   80'(0));
      chk("rst_out_data",  out_data,       80'(0));
      chk("rst_overrun",   80'(overrun),   80'(0));
      chk("rst_timeout",   80'(timeout_err), 80'(0));
      @(negedge clk);
      reset = 1'b0;

      // 1: all enabled, ack high
      x0 = xfer_total;
      run_pass(5'b11111, {16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, -1, -1, -1, 1'b0, lat);
      chk("t1_latency", 80'(lat), 80'(11));
      chk("t1_data", out_data, {16'hEFFB, 16'hEFFC, 16'hEFFD, 16'hEFFE, 16'hEFFF});
      chk("t1_xfers", 80'(xfer_total - x0), 80'(5));
      chk("t1_ch_seq", 80'(ch_seq), 80'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
      @(posedge clk);
      #1;
      chk("t1_valid_one_cycle", 80'({out_valid, busy}), 80'(0));

      // 2: channels 1 and 3 bypassed
      x0 = xfer_total;
      run_pass(5'b10101, {16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, -1, -1, -1, 1'b0, lat);
      chk("t2_latency", 80'(lat), 80'(9));
      chk("t2_data", out_data, {16'hEFFB, 16'h1003, 16'hEFFD, 16'h1001, 16'hEFFF});
      chk("t2_xfers", 80'(xfer_total - x0), 80'(3));

      // 3: engine never acks channel 2 -> watchdog abort
      ack_mode = 1;
      x0 = xfer_total;
      run_pass(5'b11111, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F}, -1, -1, -1, 1'b0, lat);
      ack_mode = 0;
      chk("t3_latency", 80'(lat), 80'(11 + TIMEOUT - 1));
      chk("t3_data", out_data, {16'hEDCB, 16'hA987, 16'h9ABC, 16'h210F, 16'hF0F0});
      chk("t3_xfers", 80'(xfer_total - x0), 80'(4));
      chk("t3_timeout_set", 80'(timeout_err), 80'(1));
      chk("t3_no_overrun", 80'(overrun), 80'(0));
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("t3_timeout_clr", 80'(timeout_err), 80'(0));

      // 4: sample_ce mid-pass and on the DONE cycle
      run_pass(5'b11111, {16'h2004, 16'h2003, 16'h2002, 16'h2001, 16'h2000}, 4, 10, -1, 1'b0, lat);
      chk("t4_latency", 80'(lat), 80'(11));
      chk("t4_data", out_data, {16'hDFFB, 16'hDFFC, 16'hDFFD, 16'hDFFE, 16'hDFFF});
      chk("t4_overrun", 80'(overrun), 80'(1));
      @(posedge clk);
      #1;
      chk("t4_no_restart", 80'(busy), 80'(0));
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("t4_overrun_clr", 80'(overrun), 80'(0));
      run_pass(5'b11111, {16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 3, -1, 3, 1'b0, lat);
      chk("t4_set_wins", 80'(overrun), 80'(1));
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;

      // 5: inputs scrambled every cycle after the snapshot
      run_pass(5'b11111, {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001}, -1, -1, -1, 1'b1, lat);
      chk("t5_latency", 80'(lat), 80'(11));
      chk("t5_data", out_data, {16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'hFFFE});

      // 6: asynchronous reset while a request is outstanding
      ack_mode = 2;
      @(negedge clk);
      ch_enable = 5'b11111;
      in_data   = {16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000};
      sample_ce = 1'b1;
      @(posedge clk);
      #1;
      sample_ce = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_req_before", 80'(eng_req), 80'(1));
      #2;
      reset = 1'b1;
      #1;
      chk("t6_req_async",   80'(eng_req),   80'(0));
      chk("t6_busy_async",  80'(busy),      80'(0));
      chk("t6_valid_async", 80'(out_valid), 80'(0));
      chk("t6_data_async",  out_data,       80'(0));
      ack_mode = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_pass(5'b11111, {16'h3004, 16'h3003, 16'h3002, 16'h3001, 16'h3000}, -1, -1, -1, 1'b0, lat);
      chk("t6_latency", 80'(lat), 80'(11));
      chk("t6_data", out_data, {16'hCFFB, 16'hCFFC, 16'hCFFD, 16'hCFFE, 16'hCFFF});
      chk("t6_errs", 80'({overrun, timeout_err}), 80'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
